// File: rtl/toplama_cikarma_seri.sv
`timescale 1ns/1ps
// Serial fixed-point adder/subtractor for the calculator datapath.
// Each cycle one ADIM-bit chunk is added, least significant chunk first.
// The exact (GENISLIK+1)-bit result is extended to 2*GENISLIK bits and
// shifted up by KESIR. This matches the result layout of the other
// arithmetic units.
module toplama_cikarma_seri #(
  parameter int GENISLIK = 32,
  parameter int KESIR    = 16,
  parameter int ADIM     = 1,
  parameter int ISARETLI = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    basla,
  input  logic                    islem,
  input  logic [GENISLIK-1:0]     sayi1,
  input  logic [GENISLIK-1:0]     sayi2,
  output logic [2*GENISLIK-1:0]   sonuc,
  output logic                    hazir,
  output logic                    gecerli,
  output logic                    tasma
);

  localparam int N  = GENISLIK / ADIM;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {BOS, HESAP} durum_t;

  durum_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg;
  logic [GENISLIK-1:0]   a_reg, b_reg, s_reg;
  logic                  carry_reg;

  logic [31:0]           base;
  logic [ADIM-1:0]       a_chunk, b_chunk, sum_chunk;
  logic                  c_out;
  logic                  msb_cin;
  logic                  last_chunk;
  logic [GENISLIK-1:0]   s_fin;
  logic [GENISLIK:0]     r_exact;
  logic [2*GENISLIK-1:0] r_ext;
  logic                  ov;

  assign hazir      = (state_reg == BOS);
  assign last_chunk = (cnt_reg == CW'(N - 1));

  // Chunk adder: select the current chunk, add it with the running carry,
  // and assemble the full sum word as it stands after the final chunk.
  always_comb begin
    base                       = 32'(cnt_reg) * 32'(ADIM);
    a_chunk                    = a_reg[base +: ADIM];
    b_chunk                    = b_reg[base +: ADIM];
    {c_out, sum_chunk}         = {1'b0, a_chunk} + {1'b0, b_chunk} + (ADIM + 1)'(carry_reg);
    // Carry into the top bit of the word. It is only meaningful on the last chunk.
    msb_cin                    = sum_chunk[ADIM-1] ^ a_chunk[ADIM-1] ^ b_chunk[ADIM-1];
    s_fin                      = s_reg;
    s_fin[(N-1)*ADIM +: ADIM]  = sum_chunk;
  end

  generate
    if (ISARETLI != 0) begin : g_isaretli
      // Signed operands: the exact sign bit is A^B'^cout.
      // Overflow means the carries into and out of the MSB disagree.
      always_comb begin
        r_exact = {a_chunk[ADIM-1] ^ b_chunk[ADIM-1] ^ c_out, s_fin};
        ov      = c_out ^ msb_cin;
        r_ext   = {{(GENISLIK-1){r_exact[GENISLIK]}}, r_exact};
      end
    end else begin : g_isaretsiz
      logic sub_reg;

      // Remember the operation, because unsigned add and subtract interpret cout differently.
      always_ff @(posedge clk) begin
        if (rst) begin
          sub_reg <= 1'b0;
        end else if (hazir && basla) begin
          sub_reg <= islem;
        end
      end

      // Unsigned operands: cout is either bit GENISLIK of the sum or the inverted borrow.
      always_comb begin
        r_exact = sub_reg ? {1'b0, s_fin} : {c_out, s_fin};
        ov      = sub_reg ? ~c_out : c_out;
        r_ext   = {{(GENISLIK-1){1'b0}}, r_exact};
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOS;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: leave idle on a start, return to idle after the last chunk.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOS:     if (basla) state_next = HESAP;
      HESAP:   if (last_chunk) state_next = BOS;
      default: state_next = BOS;
    endcase
  end

  // Datapath: capture operands on accept, then run one chunk per cycle.
  // Publish the result on the last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      sonuc     <= '0;
      tasma     <= 1'b0;
      gecerli   <= 1'b0;
    end else begin
      gecerli <= 1'b0;
      if (state_reg == BOS) begin
        if (basla) begin
          a_reg     <= sayi1;
          b_reg     <= islem ? ~sayi2 : sayi2;
          carry_reg <= islem;
          cnt_reg   <= '0;
        end
      end else begin
        s_reg[base +: ADIM] <= sum_chunk;
        carry_reg           <= c_out;
        if (last_chunk) begin
          cnt_reg <= '0;
          sonuc   <= r_ext << KESIR;
          tasma   <= ov;
          gecerli <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_toplama_cikarma_seri.sv
`timescale 1ns/1ps
// Scoreboard bench for toplama_cikarma_seri.
// One instance uses the default build (signed, 1 bit per cycle).
// A second instance uses ADIM=4 with unsigned operands.
module tb_toplama_cikarma_seri;

  localparam int N0 = 32;
  localparam int N1 = 8;

  typedef struct {
    logic [63:0] s;
    logic        t;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        basla0, islem0, basla1, islem1;
  logic [31:0] a0, b0, a1, b1;
  logic [63:0] sonuc0, sonuc1;
  logic        hazir0, gecerli0, tasma0, hazir1, gecerli1, tasma1;

  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  bit          rst_q = 1'b0;
  logic [63:0] last0 = '0;
  logic [63:0] last1 = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  toplama_cikarma_seri #(.GENISLIK(32), .KESIR(16), .ADIM(1), .ISARETLI(1)) d0 (
    .clk(clk), .rst(rst), .basla(basla0), .islem(islem0), .sayi1(a0), .sayi2(b0),
    .sonuc(sonuc0), .hazir(hazir0), .gecerli(gecerli0), .tasma(tasma0)
  );

  toplama_cikarma_seri #(.GENISLIK(32), .KESIR(16), .ADIM(4), .ISARETLI(0)) d1 (
    .clk(clk), .rst(rst), .basla(basla1), .islem(islem1), .sayi1(a1), .sayi2(b1),
    .sonuc(sonuc1), .hazir(hazir1), .gecerli(gecerli1), .tasma(tasma1)
  );

  always #5 clk = ~clk;

  // Count rising edges, remember whether reset was applied, and drop any
  // outstanding expectations when a reset aborts them.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    if (rst) begin
      q0.delete();
      q1.delete();
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: the exact mathematical sum or difference, computed on
  // 64-bit integers, and a range test for overflow.
  function automatic void model(input bit sgn, input bit sub, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] s, output logic t);
    longint x;
    if (sgn) begin
      x = sub ? longint'($signed(a)) - longint'($signed(b))
              : longint'($signed(a)) + longint'($signed(b));
      t = (x > 64'sd2147483647) || (x < -64'sd2147483648);
    end else if (!sub) begin
      x = longint'({32'd0, a}) + longint'({32'd0, b});
      t = (x > 64'sd4294967295);
    end else begin
      t = (a < b);
      x = longint'({32'd0, a - b});
    end
    s = 64'(x) << 16;
  endfunction

  task automatic push0(input bit op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(1'b1, op, a, b, e.s, e.t);
    e.due = cyc + 1 + N0;
    q0.push_back(e);
  endtask

  task automatic push1(input bit op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(1'b0, op, a, b, e.s, e.t);
    e.due = cyc + 1 + N1;
    q1.push_back(e);
  endtask

  // Monitor for d0: check reset values, completions, and that the result is held.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("d0 reset sonuc", sonuc0, 64'd0);
      chk("d0 reset hazir", {63'd0, hazir0}, 64'd1);
      chk("d0 reset gecerli", {63'd0, gecerli0}, 64'd0);
      chk("d0 reset tasma", {63'd0, tasma0}, 64'd0);
      last0 = '0;
    end else if (gecerli0 === 1'b1) begin
      if (q0.size() == 0) begin
        fail_now("d0 spurious gecerli");
      end else begin
        e = q0.pop_front();
        chk("d0 sonuc", sonuc0, e.s);
        chk("d0 tasma", {63'd0, tasma0}, {63'd0, e.t});
        chk("d0 latency", 64'(cyc), 64'(e.due));
        chk("d0 hazir with gecerli", {63'd0, hazir0}, 64'd1);
        $display("d0 done cycle=%0d sonuc=%h tasma=%0b", cyc, sonuc0, tasma0);
      end
      last0 = sonuc0;
    end else begin
      chk("d0 sonuc held", sonuc0, last0);
    end
  end

  // Monitor for d1.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("d1 reset sonuc", sonuc1, 64'd0);
      chk("d1 reset hazir", {63'd0, hazir1}, 64'd1);
      last1 = '0;
    end else if (gecerli1 === 1'b1) begin
      if (q1.size() == 0) begin
        fail_now("d1 spurious gecerli");
      end else begin
        e = q1.pop_front();
        chk("d1 sonuc", sonuc1, e.s);
        chk("d1 tasma", {63'd0, tasma1}, {63'd0, e.t});
        chk("d1 latency", 64'(cyc), 64'(e.due));
        $display("d1 done cycle=%0d sonuc=%h tasma=%0b", cyc, sonuc1, tasma1);
      end
      last1 = sonuc1;
    end else begin
      chk("d1 sonuc held", sonuc1, last1);
    end
  end

  task automatic issue0(input bit op, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    @(negedge clk);
    while (hazir0 !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (hazir0 !== 1'b1) begin
      fail_now("d0 hazir timeout");
      return;
    end
    basla0 = 1'b1; islem0 = op; a0 = a; b0 = b;
    push0(op, a, b);
    $display("d0 start cycle=%0d islem=%0b a=%h b=%h", cyc, op, a, b);
    @(negedge clk);
    basla0 = 1'b0; islem0 = 1'($urandom_range(0, 1)); a0 = 32'($urandom); b0 = 32'($urandom);
  endtask

  task automatic issue1(input bit op, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    @(negedge clk);
    while (hazir1 !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (hazir1 !== 1'b1) begin
      fail_now("d1 hazir timeout");
      return;
    end
    basla1 = 1'b1; islem1 = op; a1 = a; b1 = b;
    push1(op, a, b);
    $display("d1 start cycle=%0d islem=%0b a=%h b=%h", cyc, op, a, b);
    @(negedge clk);
    basla1 = 1'b0; islem1 = 1'($urandom_range(0, 1)); a1 = 32'($urandom); b1 = 32'($urandom);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 600) begin
      @(negedge clk);
      g++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      fail_now("completion timeout");
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    basla0 = 1'b0; islem0 = 1'b0; a0 = '0; b0 = '0;
    basla1 = 1'b0; islem1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed values: plain add, signed overflow, subtraction into negative.
    issue0(1'b0, 32'h0001_8000, 32'h0002_8000); wait_idle();
    issue0(1'b0, 32'h7FFF_0000, 32'h0001_0000); wait_idle();
    issue0(1'b1, 32'h0001_0000, 32'h0003_0000); wait_idle();
    // Extremes of the signed range.
    issue0(1'b1, 32'h8000_0000, 32'h0000_0001);
    issue0(1'b0, 32'h8000_0000, 32'h8000_0000);
    issue0(1'b1, 32'h0000_0000, 32'h8000_0000);
    issue0(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_idle();

    // Reset 10 cycles into an operation aborts it; then a fresh op completes.
    issue0(1'b0, 32'h0001_8000, 32'h0002_8000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue0(1'b0, 32'h0001_8000, 32'h0002_8000); wait_idle();

    // Reset and start on the same edge: nothing may be accepted.
    @(negedge clk);
    rst = 1'b1; basla0 = 1'b1; islem0 = 1'b0; a0 = 32'h1234_0000; b0 = 32'h0001_0000;
    @(negedge clk);
    rst = 1'b0; basla0 = 1'b0;
    repeat (40) @(negedge clk);

    // basla held high: accepted only on hazir cycles, back-to-back results.
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      basla0 = 1'b1;
      islem0 = 1'($urandom_range(0, 1));
      a0 = 32'($urandom);
      b0 = 32'($urandom);
      if (hazir0 === 1'b1) push0(islem0, a0, b0);
    end
    @(negedge clk);
    basla0 = 1'b0;
    wait_idle();

    // Random operations with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      issue0(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
    end
    wait_idle();

    // Unsigned four-bit-per-cycle instance.
    issue1(1'b0, 32'hFFFF_0000, 32'h0001_0000); wait_idle();
    issue1(1'b1, 32'h0000_0001, 32'h0000_0002);
    issue1(1'b1, 32'h0000_0005, 32'h0000_0003);
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue1(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
    end
    wait_idle();

    repeat (40) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
